// File: rtl/d_sram_like_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  d_sram_like_bridge_pkg
//  Shared state encoding and access-size codes for the MEM-stage data bridge.
//  Revision: 1.0
// ============================================================================
package d_sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    DSB_IDLE      = 2'd0,
    DSB_WAIT_ADDR = 2'd1,
    DSB_WAIT_DATA = 2'd2,
    DSB_DONE      = 2'd3
  } dsb_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage
`default_nettype wire

// File: rtl/d_sram_like_bridge_if.sv
`default_nettype none
// ============================================================================
//  d_sram_like_bridge_if
//  SRAM-like data bus: request channel from the bridge, handshakes from memory.
//  Revision: 1.0
// ============================================================================
interface d_sram_like_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  data_req;
  logic                  data_wr;
  logic [1:0]            data_size;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface
`default_nettype wire

// File: rtl/d_sram_like_bridge.sv
`default_nettype none
// ============================================================================
//  d_sram_like_bridge
//  Turns a MEM-stage load/store into one SRAM-like transaction, stalls the
//  pipeline while it is outstanding and holds the read word until MEM advances.
//  Revision: 1.0
// ============================================================================
module d_sram_like_bridge
  import d_sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  mem_en,
  input  wire logic [DATA_W/8-1:0]   mem_wen,
  input  wire logic [1:0]            mem_size,
  input  wire logic [ADDR_W-1:0]     mem_addr,
  input  wire logic [DATA_W-1:0]     mem_wdata,
  input  wire logic                  stallM,
  input  wire logic                  flushM,
  output logic      [DATA_W-1:0]     mem_rdata,
  output logic                       d_stall,
  d_sram_like_bridge_if.master       bus
);

  localparam int c_STRB_W = DATA_W / 8;

  dsb_state_e             r_state;
  logic                   r_cancel;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_wr;
  logic [1:0]             r_size;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [c_STRB_W-1:0]    r_wstrb;

  logic w_idle;
  logic w_issue;
  logic w_wait_addr;
  logic w_wait_data;
  logic w_drop;

  assign w_idle      = (r_state == DSB_IDLE);
  assign w_wait_addr = (r_state == DSB_WAIT_ADDR);
  assign w_wait_data = (r_state == DSB_WAIT_DATA);
  assign w_issue     = w_idle & mem_en & ~flushM;
  // A flush arriving together with data_ok kills the result just like an earlier one.
  assign w_drop      = r_cancel | flushM;

  // Idle with nothing to issue drives a quiet bus; otherwise the latched copy stays put.
  assign bus.data_req   = w_issue | w_wait_addr;
  assign bus.data_wr    = w_idle ? (w_issue & (|mem_wen))            : r_wr;
  assign bus.data_size  = w_idle ? (w_issue ? mem_size  : '0)         : r_size;
  assign bus.data_addr  = w_idle ? (w_issue ? mem_addr  : '0)         : r_addr;
  assign bus.data_wdata = w_idle ? (w_issue ? mem_wdata : '0)         : r_wdata;
  assign bus.data_wstrb = w_idle ? (w_issue ? mem_wen   : '0)         : r_wstrb;

  assign mem_rdata = bus.data_data_ok ? bus.data_rdata : r_rdata;

  always_comb begin
    d_stall = 1'b0;
    case (r_state)
      DSB_IDLE:      d_stall = w_issue;
      DSB_WAIT_ADDR: d_stall = r_cancel ? mem_en : 1'b1;
      DSB_WAIT_DATA: d_stall = r_cancel ? mem_en : ~bus.data_data_ok;
      default:       d_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DSB_IDLE;
      r_cancel <= 1'b0;
      r_rdata  <= '0;
      r_wr     <= 1'b0;
      r_size   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      case (r_state)
        DSB_IDLE: begin
          r_cancel <= 1'b0;
          if (w_issue) begin
            r_wr    <= |mem_wen;
            r_size  <= mem_size;
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wen;
            r_state <= bus.data_addr_ok ? DSB_WAIT_DATA : DSB_WAIT_ADDR;
          end
        end
        DSB_WAIT_ADDR: begin
          if (flushM) r_cancel <= 1'b1;
          if (bus.data_addr_ok) r_state <= DSB_WAIT_DATA;
        end
        DSB_WAIT_DATA: begin
          if (bus.data_data_ok) begin
            r_cancel <= 1'b0;
            if (w_drop) begin
              r_state <= DSB_IDLE;
            end else begin
              r_rdata <= bus.data_rdata;
              r_state <= stallM ? DSB_DONE : DSB_IDLE;
            end
          end else if (flushM) begin
            r_cancel <= 1'b1;
          end
        end
        default: begin
          if (flushM || !stallM) r_state <= DSB_IDLE;
        end
      endcase
    end
  end

  a_no_same_cycle_ok : assert property (@(posedge clk) disable iff (rst)
      !((w_issue || w_wait_addr) && bus.data_addr_ok && bus.data_data_ok));

endmodule
`default_nettype wire

// File: tb/tb_d_sram_like_bridge.sv
`default_nettype none
// ============================================================================
//  tb_d_sram_like_bridge
//  Random MEM-stage traffic and a randomly paced memory, compared each cycle
//  against a transaction-level model of the bridge.
//  Revision: 1.0
// ============================================================================
module tb_d_sram_like_bridge;
  import d_sram_like_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stallM;
  logic        flushM;
  logic [31:0] mem_rdata;
  logic        d_stall;

  d_sram_like_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  d_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .stallM    (stallM),
    .flushM    (flushM),
    .mem_rdata (mem_rdata),
    .d_stall   (d_stall),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level view: a request sits on the bus, or has been accepted,
  // or its word is being held for a stalled MEM stage.
  bit          known;
  bit          pending, accepted, holding, killed;
  bit          t_wr;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata, t_word;
  logic [3:0]  t_wstrb;

  bit          issue, e_req, e_wr, e_stall, busy;
  logic [1:0]  e_size;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_wstrb;

  initial begin
    known = 0; pending = 0; accepted = 0; holding = 0; killed = 0;
    t_wr = 0; t_size = '0; t_addr = '0; t_wdata = '0; t_wstrb = '0; t_word = '0;
    rst = 1'b1; mem_en = 0; mem_wen = '0; mem_size = '0; mem_addr = '0;
    mem_wdata = '0; stallM = 0; flushM = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = '0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst       = (cyc < 3) || ($urandom_range(0, 199) == 0);
      mem_en    = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
      mem_wen   = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      case ($urandom_range(0, 2))
        0:       mem_size = SIZE_B;
        1:       mem_size = SIZE_H;
        default: mem_size = SIZE_W;
      endcase
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      flushM    = ($urandom_range(0, 9) == 0);
      stallM    = ($urandom_range(0, 2) == 0);

      busy  = pending || accepted || holding;
      issue = !busy && mem_en && !flushM;
      e_req = issue || pending;

      bus.data_addr_ok = e_req && ($urandom_range(0, 2) == 0);
      bus.data_data_ok = accepted && ($urandom_range(0, 1) == 1);
      bus.data_rdata   = $urandom;

      if (busy) begin
        e_wr = t_wr; e_size = t_size; e_addr = t_addr; e_wdata = t_wdata; e_wstrb = t_wstrb;
      end else if (issue) begin
        e_wr = (mem_wen != 0); e_size = mem_size; e_addr = mem_addr;
        e_wdata = mem_wdata; e_wstrb = mem_wen;
      end else begin
        e_wr = 0; e_size = '0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
      end

      if (killed)        e_stall = mem_en;
      else if (pending)  e_stall = 1;
      else if (accepted) e_stall = !bus.data_data_ok;
      else if (holding)  e_stall = 0;
      else               e_stall = issue;

      e_rdata = bus.data_data_ok ? bus.data_rdata : t_word;

      #1;
      if (known) begin
        check("req",   64'(bus.data_req),   64'(e_req));
        check("wr",    64'(bus.data_wr),    64'(e_wr));
        check("size",  64'(bus.data_size),  64'(e_size));
        check("addr",  64'(bus.data_addr),  64'(e_addr));
        check("wdata", 64'(bus.data_wdata), 64'(e_wdata));
        check("wstrb", 64'(bus.data_wstrb), 64'(e_wstrb));
        check("stall", 64'(d_stall),        64'(e_stall));
        check("rdata", 64'(mem_rdata),      64'(e_rdata));
      end

      @(posedge clk);
      if (rst) begin
        known = 1; pending = 0; accepted = 0; holding = 0; killed = 0;
        t_wr = 0; t_size = '0; t_addr = '0; t_wdata = '0; t_wstrb = '0; t_word = '0;
      end else if (holding) begin
        if (flushM || !stallM) holding = 0;
      end else if (accepted) begin
        if (bus.data_data_ok) begin
          accepted = 0;
          if (!(killed || flushM)) begin
            t_word  = bus.data_rdata;
            holding = stallM;
          end
          killed = 0;
        end else if (flushM) begin
          killed = 1;
        end
      end else if (pending) begin
        if (flushM) killed = 1;
        if (bus.data_addr_ok) begin
          pending = 0; accepted = 1;
        end
      end else if (issue) begin
        t_wr = (mem_wen != 0); t_size = mem_size; t_addr = mem_addr;
        t_wdata = mem_wdata; t_wstrb = mem_wen;
        if (bus.data_addr_ok) accepted = 1;
        else                  pending  = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
